// File: rtl/dadder_cp_ctrl.sv
// dadder_cp_ctrl: control-plane register block for the datapath adder (CTRL, BIAS, result/overflow counters, ID).
// Optional overflow counter enabled by defining DADDER_CP_CTRL_OVF_CNT_EN.
module dadder_cp_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_we,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  dp_en,
  output logic                  dp_sat_en,
  output logic [DATA_WIDTH-1:0] dp_bias,
  input  logic                  dp_res_vld,
  input  logic                  dp_ovf
);
  typedef enum logic {IDLE, RESP} state_t;
  localparam logic [ADDR_WIDTH-1:0] A_CTRL = ADDR_WIDTH'('h00);
  localparam logic [ADDR_WIDTH-1:0] A_BIAS = ADDR_WIDTH'('h04);
  localparam logic [ADDR_WIDTH-1:0] A_RES  = ADDR_WIDTH'('h08);
  localparam logic [ADDR_WIDTH-1:0] A_OVF  = ADDR_WIDTH'('h0C);
  localparam logic [ADDR_WIDTH-1:0] A_ID   = ADDR_WIDTH'('h10);
  localparam logic [DATA_WIDTH-1:0] ID_VAL = DATA_WIDTH'(32'hDADD0001);
  state_t                  state;
  logic                    en, sat_en, acc, err, wr_ok;
  logic                    is_ctrl, is_bias, is_res, is_ovf, is_id;
  logic [DATA_WIDTH-1:0]   bias, res_cnt, ovf_val, rd_data;
  assign dp_en     = en;
  assign dp_sat_en = sat_en;
  assign dp_bias   = bias;
  assign acc     = req_valid && req_ready;
  assign is_ctrl = req_addr == A_CTRL;
  assign is_bias = req_addr == A_BIAS;
  assign is_res  = req_addr == A_RES;
  assign is_ovf  = req_addr == A_OVF;
  assign is_id   = req_addr == A_ID;
  // Exact-match decode already rejects misaligned addresses as unmapped.
  assign err   = !(is_ctrl || is_bias || is_res || is_ovf || is_id) || (req_we && is_id);
  assign wr_ok = acc && req_we && !err;
  always_comb begin
    rd_data = is_ctrl ? DATA_WIDTH'({sat_en, en}) :
              is_bias ? bias :
              is_res  ? res_cnt :
              is_ovf  ? ovf_val :
              is_id   ? ID_VAL : '0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (state == IDLE) begin
      req_ready <= !acc;
      rsp_valid <= acc;
      state     <= acc ? RESP : IDLE;
      if (acc) begin
        rsp_rdata <= (err || req_we) ? '0 : rd_data;
        rsp_err   <= err;
      end
    end else if (rsp_ready) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      req_ready <= 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en      <= 1'b0;
      sat_en  <= 1'b0;
      bias    <= '0;
      res_cnt <= '0;
    end else begin
      if (wr_ok && is_ctrl) {sat_en, en} <= req_wdata[1:0];
      if (wr_ok && is_bias) bias <= req_wdata;
      res_cnt <= (wr_ok && is_res) ? '0 :
                 (dp_res_vld && !(&res_cnt)) ? res_cnt + DATA_WIDTH'(1) : res_cnt;
    end
  end
`ifdef DADDER_CP_CTRL_OVF_CNT_EN
  logic [DATA_WIDTH-1:0] ovf_cnt;
  assign ovf_val = ovf_cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ovf_cnt <= '0;
    else ovf_cnt <= (wr_ok && is_ovf) ? '0 :
                    (dp_res_vld && dp_ovf && !(&ovf_cnt)) ? ovf_cnt + DATA_WIDTH'(1) : ovf_cnt;
  end
`else
  logic unused_ovf;
  assign unused_ovf = dp_ovf;
  assign ovf_val = '0;
`endif
endmodule

// File: tb/tb_dadder_cp_ctrl.sv
// tb_dadder_cp_ctrl: table-driven plus randomized check of dadder_cp_ctrl against a cycle-level register model.
module tb_dadder_cp_ctrl;
`ifdef DADDER_CP_CTRL_OVF_CNT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  localparam logic [31:0] ID = 32'hDADD0001;
  logic clk = 1'b0, reset_n = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0, dp_res_vld = 1'b0, dp_ovf = 1'b0;
  logic [7:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err, dp_en, dp_sat_en;
  logic [31:0] rsp_rdata, dp_bias;
  logic r8_req_ready, r8_rsp_valid, r8_rsp_err, r8_dp_en, r8_dp_sat_en;
  logic [7:0] r8_rdata, r8_bias, last8;
  int n_tests = 0, n_fail = 0;
  bit rand_dp = 1'b0;
  bit m_busy, m_ready, e_err;
  logic [31:0] m_ctrl, m_bias, m_res, m_ovf, e_rdata;

  always #5 clk = ~clk;

  dadder_cp_ctrl dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .dp_en(dp_en),
    .dp_sat_en(dp_sat_en), .dp_bias(dp_bias), .dp_res_vld(dp_res_vld), .dp_ovf(dp_ovf));

  dadder_cp_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) u8 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(r8_req_ready),
    .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata[7:0]), .rsp_valid(r8_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(r8_rdata), .rsp_err(r8_rsp_err), .dp_en(r8_dp_en),
    .dp_sat_en(r8_dp_sat_en), .dp_bias(r8_bias), .dp_res_vld(dp_res_vld), .dp_ovf(dp_ovf));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_ready = 0; m_ctrl = 0; m_bias = 0; m_res = 0; m_ovf = 0; e_rdata = 0; e_err = 0;
  endtask

  // Architectural view: what a read/write of an address returns, from the register map alone.
  task automatic model_access(input logic [7:0] a, input bit we, output logic [31:0] rd, output bit er);
    er = 0;
    case (a)
      8'h00: rd = {30'b0, m_ctrl[1:0]};
      8'h04: rd = m_bias;
      8'h08: rd = m_res;
      8'h0C: rd = OVF_EN ? m_ovf : 32'h0;
      8'h10: begin rd = ID; er = we; end
      default: begin rd = 0; er = 1; end
    endcase
    if (er || we) rd = 0;
  endtask

  task automatic model_edge();
    bit acc, wr, clr_res, clr_ovf;
    acc = req_valid && m_ready && !m_busy;
    if (acc) model_access(req_addr, req_we, e_rdata, e_err);
    wr = acc && req_we && !e_err;
    clr_res = wr && req_addr == 8'h08;
    clr_ovf = wr && req_addr == 8'h0C;
    if (wr && req_addr == 8'h00) m_ctrl = req_wdata & 32'h3;
    if (wr && req_addr == 8'h04) m_bias = req_wdata;
    m_res = clr_res ? 0 : (dp_res_vld && m_res != 32'hFFFFFFFF) ? m_res + 1 : m_res;
    m_ovf = clr_ovf ? 0 : (OVF_EN && dp_res_vld && dp_ovf && m_ovf != 32'hFFFFFFFF) ? m_ovf + 1 : m_ovf;
    m_busy = acc ? 1'b1 : (m_busy && rsp_ready) ? 1'b0 : m_busy;
    m_ready = 1;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("req_ready", req_ready, m_ready && !m_busy);
    chk("rsp_valid", rsp_valid, m_busy);
    chk("dp_en", dp_en, m_ctrl[0]);
    chk("dp_sat_en", dp_sat_en, m_ctrl[1]);
    chk("dp_bias", dp_bias, m_bias);
    if (m_busy) begin
      chk("rsp_rdata", rsp_rdata, e_rdata);
      chk("rsp_err", rsp_err, e_err);
    end
    dp_res_vld = rand_dp ? 1'($urandom_range(0, 1)) : 1'b0;
    dp_ovf     = rand_dp ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic txn(input logic [7:0] a, input bit we, input logic [31:0] wd, input int hold,
                     input bit pulse, output logic [31:0] rd, output bit er);
    req_valid = 1; req_addr = a; req_we = we; req_wdata = wd; rsp_ready = 0;
    if (pulse) begin dp_res_vld = 1; dp_ovf = 0; end
    step();
    req_valid = 0;
    repeat (hold) step();
    rsp_ready = 1; rd = rsp_rdata; er = rsp_err; last8 = r8_rdata;
    step();
    rsp_ready = 0;
  endtask

  typedef struct {
    logic [7:0] addr; bit we; logic [31:0] wdata; int hold; logic [31:0] exp_rdata; bit exp_err;
  } vec_t;
  vec_t vecs[15];

  initial begin
    logic [31:0] rd;
    bit er;
    logic [7:0] addrs[8] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h02, 8'h41};
    vecs = '{
      '{8'h00, 1, 32'h3,        0, 32'h0,        0},
      '{8'h00, 0, 32'h0,        0, 32'h3,        0},
      '{8'h04, 1, 32'h12345678, 0, 32'h0,        0},
      '{8'h04, 0, 32'h0,        1, 32'h12345678, 0},
      '{8'h10, 0, 32'h0,        5, ID,           0},
      '{8'h14, 0, 32'h0,        0, 32'h0,        1},
      '{8'h02, 0, 32'h0,        0, 32'h0,        1},
      '{8'h10, 1, 32'h5,        2, 32'h0,        1},
      '{8'h10, 0, 32'h0,        0, ID,           0},
      '{8'h00, 1, 32'hFFFFFFFC, 0, 32'h0,        0},
      '{8'h00, 0, 32'h0,        0, 32'h0,        0},
      '{8'h08, 0, 32'h0,        0, 32'h0,        0},
      '{8'h0C, 1, 32'h0,        0, 32'h0,        0},
      '{8'h05, 0, 32'h0,        0, 32'h0,        1},
      '{8'h01, 1, 32'h3,        0, 32'h0,        1}
    };
    model_reset();
    #1;
    chk("reset req_ready", req_ready, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_rdata", rsp_rdata, 0);
    chk("reset dp_bias", dp_bias, 0);
    repeat (2) @(negedge clk);
    reset_n = 1;
    step();
    foreach (vecs[i]) begin
      txn(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].hold, 0, rd, er);
      chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d err", i), er, vecs[i].exp_err);
    end
    // Counter sequence: 10 pulses, overflow on three of them.
    txn(8'h08, 1, 0, 0, 0, rd, er);
    txn(8'h0C, 1, 0, 0, 0, rd, er);
    for (int i = 0; i < 10; i++) begin
      dp_res_vld = 1; dp_ovf = (i == 2 || i == 5 || i == 7);
      step();
    end
    txn(8'h08, 0, 0, 0, 0, rd, er);
    chk("res_cnt 10", rd, 10);
    txn(8'h0C, 0, 0, 0, 0, rd, er);
    chk("ovf_cnt", rd, OVF_EN ? 3 : 0);
    chk("ovf_cnt err", er, 0);
    txn(8'h08, 1, 32'h77, 0, 1, rd, er);
    txn(8'h08, 0, 0, 0, 1, rd, er);
    chk("clear wins", rd, 0);
    txn(8'h08, 0, 0, 0, 0, rd, er);
    chk("read pre-increment", rd, 1);
    rand_dp = 1;
    for (int i = 0; i < 200; i++)
      txn(addrs[$urandom_range(0, 7)], 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 2), 0, rd, er);
    rand_dp = 0;
    step();
    // Saturation on the 8-bit instance; the 32-bit one keeps counting.
    txn(8'h08, 1, 0, 0, 0, rd, er);
    repeat (254) begin dp_res_vld = 1; step(); end
    txn(8'h08, 0, 0, 0, 0, rd, er);
    chk("res8 ones-1", last8, 8'hFE);
    repeat (3) begin dp_res_vld = 1; step(); end
    txn(8'h08, 0, 0, 0, 0, rd, er);
    chk("res8 saturated", last8, 8'hFF);
    chk("res32 257", rd, 257);
    // Reset in the middle of a pending response.
    txn(8'h00, 1, 3, 0, 0, rd, er);
    txn(8'h04, 1, 32'hA5A5A5A5, 0, 0, rd, er);
    req_valid = 1; req_addr = 8'h10; req_we = 0;
    step();
    req_valid = 0;
    step();
    #2 reset_n = 0;
    #1;
    chk("async rsp_valid", rsp_valid, 0);
    chk("async req_ready", req_ready, 0);
    chk("async dp_en", dp_en, 0);
    chk("async dp_bias", dp_bias, 0);
    chk("async rsp_rdata", rsp_rdata, 0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1;
    step();
    txn(8'h10, 0, 0, 0, 0, rd, er);
    chk("post-reset id", rd, ID);
    txn(8'h00, 0, 0, 0, 0, rd, er);
    chk("post-reset ctrl", rd, 0);
    txn(8'h04, 0, 0, 0, 0, rd, er);
    chk("post-reset bias", rd, 0);
    txn(8'h08, 0, 0, 0, 0, rd, er);
    chk("post-reset res", rd, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
